// File: rtl/pic_priority_ack.sv
// 8259-style priority resolver and INTA acknowledge sequencer.
// Resolves masked requests against the in-service register and runs the two-pulse INTA handshake.
module pic_priority_ack #(
  parameter int VECTOR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          IRR_Input,
  input  logic [7:0]          IMR,
  input  logic                INTA_n,
  input  logic [4:0]          vector_base,
  input  logic                auto_eoi,
  input  logic                eoi_valid,
  input  logic                eoi_specific,
  input  logic [2:0]          eoi_level,
  input  logic                eoi_rotate,
  output logic                INT,
  output logic [7:0]          clear_IRR,
  output logic                freeze,
  output logic [7:0]          ISR_Output,
  output logic [VECTOR_W-1:0] data_out,
  output logic                data_out_en
);

  typedef enum logic [1:0] {S_IDLE, S_ACK1, S_WAIT2, S_ACK2} state_t;

  state_t                r_state;
  logic                  r_inta_d;
  logic [7:0]            r_isr;
  logic                  r_int;
  logic [7:0]            r_clear_irr;
  logic                  r_freeze;
  logic [VECTOR_W-1:0]   r_data_out;
  logic                  r_data_out_en;
  logic                  r_spurious;
  logic [2:0]            r_level;
  logic [2:0]            r_lowest_pri;

  state_t                w_state_nx;
  logic [7:0]            w_req;
  logic [2:0]            w_req_lvl;
  logic [2:0]            w_isr_lvl;
  logic                  w_cond;
  logic                  w_fall;
  logic                  w_rise;
  logic                  w_int_nx;
  logic [7:0]            w_clr_nx;
  logic                  w_freeze_nx;
  logic [VECTOR_W-1:0]   w_dout_nx;
  logic                  w_den_nx;
  logic                  w_spur_nx;
  logic [2:0]            w_level_nx;
  logic [2:0]            w_lowest_nx;
  logic [7:0]            w_isr_set;
  logic [7:0]            w_isr_clr;
  logic [7:0]            w_isr_nx;

  // Scan starts just above the lowest-priority level and wraps mod 8.
  function automatic logic [2:0] f_pri_level(input logic [7:0] v, input logic [2:0] lowest);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = 3'd7;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = lowest + 3'(k);
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Rank 0 is the highest priority under the current rotation.
  function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction

  assign w_req     = IRR_Input & ~IMR;
  assign w_req_lvl = f_pri_level(w_req, r_lowest_pri);
  assign w_isr_lvl = f_pri_level(r_isr, r_lowest_pri);
  assign w_cond    = (w_req != 8'd0) &&
                     ((r_isr == 8'd0) ||
                      (f_rank(w_req_lvl, r_lowest_pri) < f_rank(w_isr_lvl, r_lowest_pri)));
  assign w_fall    = r_inta_d & ~INTA_n;
  assign w_rise    = ~r_inta_d & INTA_n;

  always_comb begin
    w_state_nx  = r_state;
    w_int_nx    = r_int;
    w_clr_nx    = 8'd0;
    w_freeze_nx = r_freeze;
    w_dout_nx   = r_data_out;
    w_den_nx    = r_data_out_en;
    w_spur_nx   = r_spurious;
    w_level_nx  = r_level;
    w_lowest_nx = r_lowest_pri;
    w_isr_set   = 8'd0;
    w_isr_clr   = 8'd0;

    case (r_state)
      S_IDLE: begin
        w_int_nx = w_cond;
        if (w_fall) begin
          w_state_nx  = S_ACK1;
          w_freeze_nx = 1'b1;
          w_int_nx    = 1'b0;
          if (w_cond) begin
            w_level_nx = w_req_lvl;
            w_isr_set  = 8'b1 << w_req_lvl;
            w_clr_nx   = 8'b1 << w_req_lvl;
            w_spur_nx  = 1'b0;
          end else begin
            w_level_nx = 3'd7;
            w_spur_nx  = 1'b1;
          end
        end
      end
      S_ACK1: begin
        if (w_rise) w_state_nx = S_WAIT2;
      end
      S_WAIT2: begin
        if (w_fall) begin
          w_state_nx = S_ACK2;
          w_dout_nx  = VECTOR_W'({vector_base, r_level});
          w_den_nx   = 1'b1;
        end
      end
      S_ACK2: begin
        if (w_rise) begin
          w_state_nx  = S_IDLE;
          w_den_nx    = 1'b0;
          w_freeze_nx = 1'b0;
          if (auto_eoi && !r_spurious) w_isr_clr = 8'b1 << r_level;
          if (auto_eoi && eoi_rotate)  w_lowest_nx = r_level;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // EOI may arrive in any state; an explicit EOI rotation overrides an AEOI one.
    if (eoi_valid) begin
      if (eoi_specific) begin
        w_isr_clr = w_isr_clr | (8'b1 << eoi_level);
        if (eoi_rotate) w_lowest_nx = eoi_level;
      end else if (r_isr != 8'd0) begin
        w_isr_clr = w_isr_clr | (8'b1 << w_isr_lvl);
        if (eoi_rotate) w_lowest_nx = w_isr_lvl;
      end
    end

    w_isr_nx = (r_isr & ~w_isr_clr) | w_isr_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_inta_d      <= 1'b1;
      r_isr         <= 8'd0;
      r_int         <= 1'b0;
      r_clear_irr   <= 8'd0;
      r_freeze      <= 1'b0;
      r_data_out    <= '0;
      r_data_out_en <= 1'b0;
      r_spurious    <= 1'b0;
      r_level       <= 3'd7;
      r_lowest_pri  <= 3'd7;
    end else begin
      r_state       <= w_state_nx;
      r_inta_d      <= INTA_n;
      r_isr         <= w_isr_nx;
      r_int         <= w_int_nx;
      r_clear_irr   <= w_clr_nx;
      r_freeze      <= w_freeze_nx;
      r_data_out    <= w_dout_nx;
      r_data_out_en <= w_den_nx;
      r_spurious    <= w_spur_nx;
      r_level       <= w_level_nx;
      r_lowest_pri  <= w_lowest_nx;
    end
  end

  assign INT         = r_int;
  assign clear_IRR   = r_clear_irr;
  assign freeze      = r_freeze;
  assign ISR_Output  = r_isr;
  assign data_out    = r_data_out;
  assign data_out_en = r_data_out_en;

endmodule

// File: tb/tb_pic_priority_ack.sv
// Scoreboard bench for pic_priority_ack: stimulus queues expectations, a negedge monitor consumes them.
module tb_pic_priority_ack;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] IRR_Input;
  logic [7:0] IMR;
  logic       INTA_n;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       INT;
  logic [7:0] clear_IRR;
  logic       freeze;
  logic [7:0] ISR_Output;
  logic [7:0] data_out;
  logic       data_out_en;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       i;
    logic [7:0] isr;
    logic       frz;
    logic       den;
    logic       dchk;
    logic [7:0] dout;
  } snap_t;

  typedef struct packed {
    logic [7:0] clr;
    logic [7:0] isr;
  } clr_t;

  snap_t      q_snap[$];
  clr_t       q_clr[$];
  logic [7:0] q_vec[$];
  logic [7:0] q_frz[$];

  pic_priority_ack #(.VECTOR_W(8)) dut (
    .clk(clk), .reset(reset), .IRR_Input(IRR_Input), .IMR(IMR), .INTA_n(INTA_n),
    .vector_base(vector_base), .auto_eoi(auto_eoi), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
    .INT(INT), .clear_IRR(clear_IRR), .freeze(freeze), .ISR_Output(ISR_Output),
    .data_out(data_out), .data_out_en(data_out_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor
  logic [7:0] prev_clr = 8'd0;
  logic       prev_den = 1'b0;
  logic       prev_frz = 1'b0;

  always @(negedge clk) begin
    clr_t  ec;
    snap_t es;
    logic [7:0] ev;
    if (prev_clr != 8'd0) begin
      checks++;
      if (clear_IRR != 8'd0) begin
        errors++;
        $display("FAIL clr_width: clear_IRR=%h, required 00 one cycle after pulse", clear_IRR);
      end
    end
    if (clear_IRR != 8'd0) begin
      checks++;
      if (q_clr.size() == 0) begin
        errors++;
        $display("FAIL clr_unexpected: clear_IRR=%h with no pulse expected", clear_IRR);
      end else begin
        ec = q_clr.pop_front();
        if (clear_IRR !== ec.clr || ISR_Output !== ec.isr) begin
          errors++;
          $display("FAIL clr_pulse: clear_IRR=%h ISR=%h, required clear_IRR=%h ISR=%h",
                   clear_IRR, ISR_Output, ec.clr, ec.isr);
        end
      end
    end
    if (data_out_en && !prev_den) begin
      checks++;
      if (q_vec.size() == 0) begin
        errors++;
        $display("FAIL vec_unexpected: data_out=%h driven with no vector expected", data_out);
      end else begin
        ev = q_vec.pop_front();
        if (data_out !== ev) begin
          errors++;
          $display("FAIL vector: data_out=%h, required %h", data_out, ev);
        end
      end
    end
    if (!freeze && prev_frz) begin
      checks++;
      if (q_frz.size() == 0) begin
        errors++;
        $display("FAIL frz_unexpected: freeze dropped with ISR=%h unexpectedly", ISR_Output);
      end else begin
        ev = q_frz.pop_front();
        if (ISR_Output !== ev) begin
          errors++;
          $display("FAIL seq_end_isr: ISR=%h at freeze release, required %h", ISR_Output, ev);
        end
      end
    end
    if (q_snap.size() != 0) begin
      es = q_snap.pop_front();
      checks++;
      if (INT !== es.i || ISR_Output !== es.isr || freeze !== es.frz || data_out_en !== es.den ||
          (es.dchk && (data_out !== es.dout || clear_IRR !== 8'd0))) begin
        errors++;
        $display("FAIL snapshot: INT=%b ISR=%h freeze=%b den=%b dout=%h clr=%h, required INT=%b ISR=%h freeze=%b den=%b dout=%h(chk=%b)",
                 INT, ISR_Output, freeze, data_out_en, data_out, clear_IRR,
                 es.i, es.isr, es.frz, es.den, es.dout, es.dchk);
      end
    end
    prev_clr = clear_IRR;
    prev_den = data_out_en;
    prev_frz = freeze;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic i, input logic [7:0] isr, input logic frz, input logic den);
    q_snap.push_back('{i: i, isr: isr, frz: frz, den: den, dchk: 1'b0, dout: 8'd0});
  endtask

  // Two single-cycle INTA pulses; IRR_Input takes irr_after once the first pulse is seen.
  task automatic ack(input logic [7:0] exp_clr, input logic [7:0] exp_isr1, input logic [7:0] exp_vec,
                     input logic [7:0] exp_isr_end, input logic [7:0] irr_after);
    if (exp_clr != 8'd0) q_clr.push_back('{clr: exp_clr, isr: exp_isr1});
    INTA_n = 1'b0;
    tick();
    snap(1'b0, exp_isr1, 1'b1, 1'b0);
    IRR_Input = irr_after;
    INTA_n = 1'b1;
    tick();
    q_vec.push_back(exp_vec);
    INTA_n = 1'b0;
    tick();
    q_frz.push_back(exp_isr_end);
    INTA_n = 1'b1;
    tick();
  endtask

  task automatic eoi(input logic specific, input logic [2:0] lvl, input logic rot);
    eoi_valid = 1'b1;
    eoi_specific = specific;
    eoi_level = lvl;
    eoi_rotate = rot;
    tick();
    eoi_valid = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IRR_Input = 8'd0; IMR = 8'd0; INTA_n = 1'b1; vector_base = 5'b01000;
    auto_eoi = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; eoi_rotate = 1'b0;
    tick();
    q_snap.push_back('{i: 1'b0, isr: 8'd0, frz: 1'b0, den: 1'b0, dchk: 1'b1, dout: 8'd0});
    tick();
    reset = 1'b0;

    // Basic flow: IR1 and IR4 pending, IR1 wins
    IRR_Input = 8'b0001_0010;
    tick();
    snap(1'b1, 8'h00, 1'b0, 1'b0);
    ack(8'b0000_0010, 8'b0000_0010, 8'h41, 8'b0000_0010, 8'b0001_0000);
    tick();
    snap(1'b0, 8'h02, 1'b0, 1'b0);
    eoi(1'b0, 3'd0, 1'b0);
    snap(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    snap(1'b1, 8'h00, 1'b0, 1'b0);
    IRR_Input = 8'd0;
    tick();
    tick();

    // Nesting
    IRR_Input = 8'b0000_0100;
    tick();
    ack(8'h04, 8'h04, 8'h42, 8'h04, 8'h00);
    IRR_Input = 8'b0010_0000;
    tick();
    tick();
    snap(1'b0, 8'h04, 1'b0, 1'b0);
    IRR_Input = 8'b0010_0001;
    tick();
    snap(1'b1, 8'h04, 1'b0, 1'b0);
    ack(8'h01, 8'h05, 8'h40, 8'h05, 8'b0010_0000);
    eoi(1'b0, 3'd0, 1'b0);
    snap(1'b0, 8'h04, 1'b0, 1'b0);
    IRR_Input = 8'd0;
    eoi(1'b1, 3'd2, 1'b0);
    snap(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // AEOI with rotation
    auto_eoi = 1'b1;
    eoi_rotate = 1'b1;
    IRR_Input = 8'b0000_1000;
    tick();
    ack(8'h08, 8'h08, 8'h43, 8'h00, 8'h00);
    IRR_Input = 8'b0001_0100;
    tick();
    snap(1'b1, 8'h00, 1'b0, 1'b0);
    ack(8'h10, 8'h10, 8'h44, 8'h00, 8'b0000_0100);
    tick();
    snap(1'b1, 8'h00, 1'b0, 1'b0);
    ack(8'h04, 8'h04, 8'h42, 8'h00, 8'h00);
    auto_eoi = 1'b0;
    eoi(1'b1, 3'd7, 1'b1);
    snap(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Spurious: IR6 withdraws before INTA
    IRR_Input = 8'b0100_0000;
    tick();
    snap(1'b1, 8'h00, 1'b0, 1'b0);
    IRR_Input = 8'd0;
    ack(8'h00, 8'h00, 8'h47, 8'h00, 8'h00);
    tick();

    // Mask, then specific EOI of IR7 with IR3 nested
    IMR = 8'hFF;
    IRR_Input = 8'hFF;
    tick();
    tick();
    snap(1'b0, 8'h00, 1'b0, 1'b0);
    IMR = 8'h00;
    IRR_Input = 8'b1000_0000;
    tick();
    ack(8'h80, 8'h80, 8'h47, 8'h80, 8'h00);
    IRR_Input = 8'b0000_1000;
    tick();
    snap(1'b1, 8'h80, 1'b0, 1'b0);
    ack(8'h08, 8'h88, 8'h43, 8'h88, 8'h00);
    eoi(1'b1, 3'd7, 1'b0);
    snap(1'b0, 8'h08, 1'b0, 1'b0);
    eoi(1'b0, 3'd0, 1'b0);
    snap(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Reset while waiting for the second INTA
    IRR_Input = 8'b0000_0010;
    tick();
    q_clr.push_back('{clr: 8'h02, isr: 8'h02});
    INTA_n = 1'b0;
    tick();
    IRR_Input = 8'd0;
    INTA_n = 1'b1;
    tick();
    snap(1'b0, 8'h02, 1'b1, 1'b0);
    q_frz.push_back(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_snap.push_back('{i: 1'b0, isr: 8'd0, frz: 1'b0, den: 1'b0, dchk: 1'b1, dout: 8'd0});
    IRR_Input = 8'b0000_0010;
    tick();
    snap(1'b1, 8'h00, 1'b0, 1'b0);
    ack(8'h02, 8'h02, 8'h41, 8'h02, 8'h00);
    eoi(1'b0, 3'd0, 1'b0);
    snap(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    tick();

    while (q_snap.size() != 0) begin void'(q_snap.pop_front()); checks++; errors++;
      $display("FAIL drain_snap: snapshot never consumed, required none pending"); end
    while (q_clr.size() != 0) begin void'(q_clr.pop_front()); checks++; errors++;
      $display("FAIL drain_clr: expected clear_IRR pulse never seen"); end
    while (q_vec.size() != 0) begin void'(q_vec.pop_front()); checks++; errors++;
      $display("FAIL drain_vec: expected vector drive never seen"); end
    while (q_frz.size() != 0) begin void'(q_frz.pop_front()); checks++; errors++;
      $display("FAIL drain_frz: expected freeze release never seen"); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
